// File: rtl/pipe_mac_lanes.sv
// LANES-wide multiply/add pipeline: registered products, adder tree, then an
// accumulator that emits a partial sum with a sticky overflow flag on par_done.
module pipe_mac_lanes #(
  parameter int IF_CELL_SIZE     = 8,
  parameter int FILTER_CELL_SIZE = 8,
  parameter int LANES            = 4,
  parameter int ACC_EXTRA        = 4,
  parameter int SIGNED           = 0,
  parameter int SATURATE         = 1,
  localparam int OUT_W = IF_CELL_SIZE + FILTER_CELL_SIZE + $clog2(LANES) + ACC_EXTRA
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [LANES*IF_CELL_SIZE-1:0]       if_in,
  input  logic [LANES*FILTER_CELL_SIZE-1:0]   filter_in,
  input  logic                                par_done,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [OUT_W-1:0]                    out,
  output logic                                out_ovf,
  output logic                                busy
);

  localparam int PROD_W = IF_CELL_SIZE + FILTER_CELL_SIZE;
  localparam int SUM_W  = PROD_W + $clog2(LANES);
  localparam int EXT_W  = OUT_W + 1;
  localparam int NODES  = 2 * LANES - 1;
  localparam logic [OUT_W-1:0] SMIN = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [OUT_W-1:0] SMAX = {1'b0, {(OUT_W-1){1'b1}}};

  logic              advance;
  logic              accept;
  logic [PROD_W-1:0] prod_d [LANES];
  logic [PROD_W-1:0] prod_q [LANES];
  logic              s1_valid_q, s1_last_q;
  logic [SUM_W-1:0]  node [NODES];
  logic              s2_valid_q, s2_last_q;
  logic [SUM_W-1:0]  s2_sum_q;
  logic [EXT_W-1:0]  acc_ext, sum_ext, total;
  logic              ovf;
  logic [OUT_W-1:0]  res;
  logic              acc_fire;
  logic [OUT_W-1:0]  acc_q, acc_d, out_q, out_d;
  logic              sticky_q, sticky_d, open_q, open_d;
  logic              out_ovf_q, out_ovf_d, out_valid_q, out_valid_d;

  // Every stage moves together; only a held, untaken result freezes the pipe.
  assign advance  = ~(out_valid_q & ~out_ready);
  assign in_ready = advance;
  assign accept   = in_valid & advance;
  assign acc_fire = advance & s2_valid_q;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [IF_CELL_SIZE-1:0]     a;
    logic [FILTER_CELL_SIZE-1:0] b;
    logic [PROD_W-1:0]           a_ext, b_ext;
    assign a     = if_in[gi*IF_CELL_SIZE +: IF_CELL_SIZE];
    assign b     = filter_in[gi*FILTER_CELL_SIZE +: FILTER_CELL_SIZE];
    assign a_ext = (SIGNED != 0) ? PROD_W'($signed(a)) : PROD_W'(a);
    assign b_ext = (SIGNED != 0) ? PROD_W'($signed(b)) : PROD_W'(b);
    // The exact product fits PROD_W bits in either mode, so the low bits suffice.
    assign prod_d[gi] = a_ext * b_ext;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      for (int i = 0; i < LANES; i++) prod_q[i] <= '0;
    end else if (advance) begin
      s1_valid_q <= accept;
      s1_last_q  <= accept & par_done;
      if (accept) begin
        for (int i = 0; i < LANES; i++) prod_q[i] <= prod_d[i];
      end
    end
  end

  // Heap-ordered tree: leaves at LANES-1.., node i sums children 2i+1 and 2i+2.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      node[LANES-1+i] = (SIGNED != 0) ? SUM_W'($signed(prod_q[i])) : SUM_W'(prod_q[i]);
    end
    for (int i = LANES - 2; i >= 0; i--) begin
      node[i] = node[2*i+1] + node[2*i+2];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_valid_q <= 1'b0;
      s2_last_q  <= 1'b0;
      s2_sum_q   <= '0;
    end else if (advance) begin
      s2_valid_q <= s1_valid_q;
      s2_last_q  <= s1_last_q;
      s2_sum_q   <= node[0];
    end
  end

  always_comb begin
    acc_ext = (SIGNED != 0) ? EXT_W'($signed(acc_q))    : EXT_W'(acc_q);
    sum_ext = (SIGNED != 0) ? EXT_W'($signed(s2_sum_q)) : EXT_W'(s2_sum_q);
    total   = acc_ext + sum_ext;
    // One guard bit is enough: both addends fit OUT_W bits.
    ovf     = (SIGNED != 0) ? (total[OUT_W] ^ total[OUT_W-1]) : total[OUT_W];
    res     = total[OUT_W-1:0];
    if (ovf && (SATURATE != 0)) begin
      if (SIGNED != 0) res = total[OUT_W] ? SMIN : SMAX;
      else             res = '1;
    end

    acc_d       = acc_q;
    sticky_d    = sticky_q;
    open_d      = open_q;
    out_d       = out_q;
    out_ovf_d   = out_ovf_q;
    out_valid_d = out_valid_q;

    if (acc_fire) begin
      if (s2_last_q) begin
        out_d     = res;
        out_ovf_d = sticky_q | ovf;
        acc_d     = '0;
        sticky_d  = 1'b0;
        open_d    = 1'b0;
      end else begin
        acc_d     = res;
        sticky_d  = sticky_q | ovf;
        open_d    = 1'b1;
      end
    end

    if (acc_fire && s2_last_q) out_valid_d = 1'b1;
    else if (out_ready)        out_valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q       <= '0;
      sticky_q    <= 1'b0;
      open_q      <= 1'b0;
      out_q       <= '0;
      out_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      sticky_q    <= sticky_d;
      open_q      <= open_d;
      out_q       <= out_d;
      out_ovf_q   <= out_ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out       = out_q;
  assign out_ovf   = out_ovf_q;
  assign out_valid = out_valid_q;
  assign busy      = s1_valid_q | s2_valid_q | open_q | out_valid_q;

endmodule

// File: tb/tb_pipe_mac_lanes.sv
// Four parameter variants of pipe_mac_lanes share one stimulus stream; each has
// its own expected-result queue filled by an arithmetic model and drained by a monitor.
module tb_pipe_mac_lanes;

  localparam int N = 4;
  localparam int W_T   [N] = '{22, 18, 22, 18};
  localparam bit SG_T  [N] = '{1'b0, 1'b0, 1'b1, 1'b0};
  localparam bit SAT_T [N] = '{1'b1, 1'b1, 1'b1, 1'b0};

  typedef struct packed {
    logic [31:0] val;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, par_done, out_ready;
  logic [31:0] if_in, filter_in;
  logic [N-1:0] in_ready_v, out_valid_v, ovf_v, busy_v;
  logic [21:0] out0, out2;
  logic [17:0] out1, out3;
  logic [31:0] out_v [N];

  assign out_v[0] = 32'(out0);
  assign out_v[1] = 32'(out1);
  assign out_v[2] = 32'(out2);
  assign out_v[3] = 32'(out3);

  exp_t   exp_q [N][$];
  longint m_acc [N];
  bit     m_sticky [N];
  exp_t   mon_e;
  int     checks = 0;
  int     failures = 0;
  bit     rand_done;

  pipe_mac_lanes dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_v[0]),
    .if_in(if_in), .filter_in(filter_in), .par_done(par_done),
    .out_valid(out_valid_v[0]), .out_ready(out_ready), .out(out0),
    .out_ovf(ovf_v[0]), .busy(busy_v[0]));

  pipe_mac_lanes #(.ACC_EXTRA(0)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_v[1]),
    .if_in(if_in), .filter_in(filter_in), .par_done(par_done),
    .out_valid(out_valid_v[1]), .out_ready(out_ready), .out(out1),
    .out_ovf(ovf_v[1]), .busy(busy_v[1]));

  pipe_mac_lanes #(.SIGNED(1)) u_sgn (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_v[2]),
    .if_in(if_in), .filter_in(filter_in), .par_done(par_done),
    .out_valid(out_valid_v[2]), .out_ready(out_ready), .out(out2),
    .out_ovf(ovf_v[2]), .busy(busy_v[2]));

  pipe_mac_lanes #(.ACC_EXTRA(0), .SATURATE(0)) u_wrap (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_v[3]),
    .if_in(if_in), .filter_in(filter_in), .par_done(par_done),
    .out_valid(out_valid_v[3]), .out_ready(out_ready), .out(out3),
    .out_ovf(ovf_v[3]), .busy(busy_v[3]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: dot product as plain integers, range test, clamp or wrap.
  function automatic void model_beat(int k, logic [31:0] ifv, logic [31:0] fv, bit last);
    longint dot, a, b, span, lo, hi, t, r;
    bit     ov;
    exp_t   e;
    dot = 0;
    for (int l = 0; l < 4; l++) begin
      a = longint'(ifv[l*8 +: 8]);
      b = longint'(fv[l*8 +: 8]);
      if (SG_T[k]) begin
        if (a > 127) a -= 256;
        if (b > 127) b -= 256;
      end
      dot += a * b;
    end
    span = longint'(1) << W_T[k];
    if (SG_T[k]) begin lo = -(span / 2); hi = span / 2 - 1; end
    else         begin lo = 0;           hi = span - 1;     end
    t  = m_acc[k] + dot;
    ov = (t < lo) || (t > hi);
    if (!ov)          r = t;
    else if (SAT_T[k]) r = (t > hi) ? hi : lo;
    else begin
      r = t % span;
      if (r < 0) r += span;
      if (SG_T[k] && r > hi) r -= span;
    end
    if (last) begin
      e.val = 32'(r) & 32'(span - 1);
      e.ovf = m_sticky[k] | ov;
      exp_q[k].push_back(e);
      m_acc[k]    = 0;
      m_sticky[k] = 1'b0;
    end else begin
      m_acc[k]    = r;
      m_sticky[k] = m_sticky[k] | ov;
    end
  endfunction

  function automatic void reset_model();
    for (int k = 0; k < N; k++) begin
      exp_q[k].delete();
      m_acc[k]    = 0;
      m_sticky[k] = 1'b0;
    end
  endfunction

  function automatic int pending();
    int p;
    p = 0;
    for (int k = 0; k < N; k++) p += exp_q[k].size() + int'(busy_v[k]);
    return p;
  endfunction

  always @(negedge clk) begin
    if (rst && out_ready) begin
      for (int k = 0; k < N; k++) begin
        if (out_valid_v[k]) begin
          if (exp_q[k].size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_result inst%0d: got 0x%0h expected none", k, out_v[k]);
          end else begin
            mon_e = exp_q[k].pop_front();
            check($sformatf("result_inst%0d", k), out_v[k], mon_e.val);
            check($sformatf("ovf_inst%0d", k), 32'(ovf_v[k]), 32'(mon_e.ovf));
            $display("result inst%0d out=0x%0h ovf=%0d", k, out_v[k], ovf_v[k]);
          end
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input bit last);
    bit took, ok;
    took = 1'b0;
    in_valid = 1'b1; if_in = a; filter_in = b; par_done = last;
    for (int n = 0; n < 300 && !took; n++) begin
      @(negedge clk);
      ok = in_ready_v[0];
      @(posedge clk);
      if (ok) begin
        for (int k = 0; k < N; k++) model_beat(k, a, b, last);
        took = 1'b1;
      end
    end
    if (!took) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: got in_ready=0 expected acceptance");
    end
    #1;
    in_valid = 1'b0;
    if_in = $urandom; filter_in = $urandom; par_done = 1'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (n < 300 && pending() != 0) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", 32'(pending()), 32'd0);
  endtask

  task automatic wait_valid(input int k);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 50 && !seen; n++) begin
      @(negedge clk);
      seen = out_valid_v[k];
    end
    check($sformatf("wait_valid_inst%0d", k), 32'(seen), 32'd1);
  endtask

  localparam logic [31:0] A = 32'h04030201;
  localparam logic [31:0] B = 32'h08070605;
  localparam logic [31:0] C = 32'hFFFFFFFF;
  localparam logic [31:0] D = 32'h02020202;

  initial begin
    rst = 1'b0; in_valid = 1'b0; if_in = '0; filter_in = '0; par_done = 1'b0; out_ready = 1'b1;
    rand_done = 1'b0;
    reset_model();
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid_v), 32'd0);
    check("rst_busy", 32'(busy_v), 32'd0);
    check("rst_out", out_v[0], 32'd0);
    check("rst_ovf", 32'(ovf_v), 32'd0);
    #2 rst = 1'b1;
    @(negedge clk);
    check("in_ready_after_rst", 32'(in_ready_v), 32'hF);

    // Single beat: latency and one-cycle pulse.
    @(posedge clk); #1;
    send(A, B, 1'b1);
    @(negedge clk); check("lat_e0", 32'(out_valid_v[0]), 32'd0);
    @(negedge clk); check("lat_e1", 32'(out_valid_v[0]), 32'd0);
    @(negedge clk); check("lat_e2", 32'(out_valid_v[0]), 32'd1);
    check("single_out", out_v[0], 32'd70);
    @(negedge clk); check("pulse_one_cycle", 32'(out_valid_v[0]), 32'd0);
    drain();

    // Two-beat sum, then a single beat with no bubble.
    @(posedge clk); #1;
    send(A, B, 1'b0);
    send(A, B, 1'b1);
    send(A, B, 1'b1);
    drain();

    // Backpressure: four single-beat sums against a held result.
    @(posedge clk); #1;
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) send(A, B, 1'b1);
      end
      begin
        repeat (12) @(negedge clk);
        check("stall_in_ready", 32'(in_ready_v[0]), 32'd0);
        check("stall_out_valid", 32'(out_valid_v[0]), 32'd1);
        check("stall_out_hold", out_v[0], 32'd70);
        check("stall_busy", 32'(busy_v[0]), 32'd1);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Saturation on the 18-bit variant, then a clean sum.
    @(posedge clk); #1;
    send(C, C, 1'b0);
    send(C, C, 1'b1);
    wait_valid(1);
    check("sat_out", out_v[1], 32'd262143);
    check("sat_ovf", 32'(ovf_v[1]), 32'd1);
    drain();
    @(posedge clk); #1;
    send(A, B, 1'b1);
    drain();

    // Signed: -1 x 2 on every lane.
    @(posedge clk); #1;
    send(C, D, 1'b1);
    wait_valid(2);
    check("signed_out", out_v[2], 32'h003FFFF8);
    check("signed_ovf", 32'(ovf_v[2]), 32'd0);
    drain();

    // Random beats, gaps and backpressure.
    @(posedge clk); #1;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(3) == 0) begin @(posedge clk); #1; end
          send($urandom, $urandom, $urandom_range(2) == 0);
        end
        send($urandom, $urandom, 1'b1);
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Asynchronous reset with a partial sum open.
    @(posedge clk); #1;
    send(A, B, 1'b0);
    @(negedge clk);
    check("pre_reset_busy", 32'(busy_v[0]), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("async_rst_out_valid", 32'(out_valid_v), 32'd0);
    check("async_rst_busy", 32'(busy_v), 32'd0);
    check("async_rst_out", out_v[0], 32'd0);
    reset_model();
    @(negedge clk);
    #3 rst = 1'b1;
    @(posedge clk); #1;
    send(A, B, 1'b1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pipe_mac_lanes.md
Name: pipe_mac_lanes

Overview:
- Parametrised successor to the single-channel pipelined multiply/add unit: LANES parallel if×filter products, an adder tree, then an accumulator, all in one pipeline.
- Accumulates a partial sum over any number of beats; par_done marks the last beat of each partial sum.
- Adds valid/ready handshakes on both sides, backpressure stall, signed/unsigned mode and optional saturation with a sticky overflow flag.
- Feeds convolution partial sums to the downstream output buffer.

Parameters:
- IF_CELL_SIZE, 8, bits per input-feature cell.
- FILTER_CELL_SIZE, 8, bits per filter cell.
- LANES, 4, parallel products per beat (power of two, ≥1).
- ACC_EXTRA, 4, extra accumulator guard bits.
- SIGNED, 0, 0 = unsigned, 1 = two's complement operands and result.
- SATURATE, 1, 1 = clamp accumulator at range limits, 0 = wrap modulo 2^OUT_W.
- Local: OUT_W = IF_CELL_SIZE + FILTER_CELL_SIZE + clog2(LANES) + ACC_EXTRA.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block accepts beat.
- if_in  in  LANES*IF_CELL_SIZE  feature cells, lane 0 in LSBs.
- filter_in  in  LANES*FILTER_CELL_SIZE  filter cells, lane 0 in LSBs.
- par_done  in  1  accepted beat is the last of its partial sum.
- out_valid  out  1  result held on out.
- out_ready  in  1  downstream takes result.
- out  out  OUT_W  partial-sum result.
- out_ovf  out  1  this result saturated/wrapped at least once.
- busy  out  1  any pipeline stage or accumulator holds data.

Behaviour:
- Reset (rst=0, async):
  - All stage valids, accumulator, out, out_valid, out_ovf and the sticky overflow are cleared to 0.
  - in_ready=1 once rst=1.
  - A reset mid-partial-sum discards everything.
- Accept: a beat is taken on an edge with in_valid & in_ready. par_done is sampled only then; otherwise it is ignored.
- Pipeline:
  - Acceptance edge E0: LANES products are registered in S1, with last flag = par_done.
  - E0+1: the adder-tree sum is registered in S2.
  - E0+2: the S2 sum is added into the accumulator.
  - Latency: out_valid rises in the cycle after E0+2 for a last beat.
- Arithmetic:
  - Products are full width (IF+FILTER bits), sign-extended when SIGNED=1.
  - The tree sum is exact at IF+FILTER+clog2(LANES) bits.
  - The accumulator is OUT_W bits.
- Overflow:
  - When acc+sum leaves the OUT_W range (unsigned 0..2^OUT_W−1; signed −2^(OUT_W−1)..2^(OUT_W−1)−1), the sticky overflow is set.
  - SATURATE=1 clamps to the nearest limit; SATURATE=0 wraps.
- Last beat at the accumulate edge:
  - out ← acc+sum (clamped/wrapped).
  - out_ovf ← sticky OR this-edge overflow.
  - out_valid ← 1; accumulator ← 0; sticky ← 0.
  - The next beat starts a fresh sum with no bubble.
- Single-beat partial sum (par_done on the first beat) is legal: out = that beat's dot product.
- Output holding:
  - out and out_ovf are stable while out_valid=1 and out_ready=0.
  - out_valid clears on an edge with out_ready=1, unless a new last beat loads in on the same edge, in which case out_valid stays 1 with the new value.
- Stall:
  - stall = out_valid & ~out_ready; in_ready = ~stall.
  - While stalled, S1, S2 and the accumulator all hold; no beat is lost or duplicated.
  - Stall removal resumes on the next edge.
- busy = S1 valid | S2 valid | (accumulator holds an open partial sum) | out_valid.
- Simultaneous cases:
  - in_valid with out_ready on the same edge while out_valid: the beat is accepted, because in_ready is computed from the registered out_valid and out_ready.

Test Plan:
- Defaults, one beat: if lanes {1,2,3,4}, filter {5,6,7,8}, par_done=1, out_ready=1 → out=70 (5+12+21+32) in the cycle after E0+2, out_ovf=0, out_valid for exactly one cycle.
- Two-beat sum: the same beat twice back-to-back, par_done on the 2nd only → a single result 140. Then a 3rd beat with par_done → 70, confirming the accumulator cleared with no bubble.
- Backpressure: out_ready=0 while a result is pending; stream 3 further single-beat sums of 70 → in_ready=0 after the pipeline fills, out holds 70. Raise out_ready → exactly four results of 70 in order, none lost or duplicated.
- Saturation, ACC_EXTRA=0 (OUT_W=18), unsigned, all cells 255: two beats of 260100 each, par_done on the 2nd → out=262143, out_ovf=1. The following single beat of 70 → out=70, out_ovf=0.
- Signed, SIGNED=1: if cells 0xFF (−1), filter cells 2, one beat → out = −8 (0x3FFFF8 at OUT_W=22), out_ovf=0.
- Reset mid-sum: accept one beat without par_done, pull rst low asynchronously → out_valid, busy and out are 0 immediately. After release, a single beat of 70 → out=70 (no residue from before reset).
